// File: rtl/updown_counter.sv
// updown_counter: parametrised synchronous up/down modulo counter with parallel
// load, cascadable terminal count and a sticky wrap flag.
// Build option: define UPDOWN_COUNTER_SATURATE_EN to saturate at the range ends
// instead of wrapping; wrapped then records a blocked count.

module updown_counter #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] state,
  output logic             tc,
  output logic             wrapped
);

  // Reject an out-of-range modulus at elaboration time.
  if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : gen_bad_modulus
    $error("updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable for the clamp compare.
  localparam logic [WIDTH:0]   ModWide = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] state_q, state_d;
  logic             wrapped_q, wrapped_d;
  logic             at_max, at_zero;
  logic             wrap_evt;

  assign at_max  = (state_q == MaxVal);
  assign at_zero = (state_q == '0);

  // Next-state selection: load beats count; range ends wrap or saturate.
  always_comb begin
    state_d  = state_q;
    wrap_evt = 1'b0;
    if (load) begin
      if ({1'b0, load_val} >= ModWide) begin
        state_d = MaxVal;
      end else begin
        state_d = load_val;
      end
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          wrap_evt = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
          state_d  = MaxVal;
`else
          state_d  = '0;
`endif
        end else begin
          state_d = state_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          wrap_evt = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
          state_d  = '0;
`else
          state_d  = MaxVal;
`endif
        end else begin
          state_d = state_q - WIDTH'(1);
        end
      end
    end
  end

  // Sticky flag: a wrap on the same edge as a clear wins.
  always_comb begin
    wrapped_d = wrapped_q;
    if (wrap_evt) begin
      wrapped_d = 1'b1;
    end else if (clr_flag) begin
      wrapped_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign tc      = en & ~load & (up ? at_max : at_zero);
  assign state   = state_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter (WIDTH=3, MODULUS=6), including a
// two-stage cascade built from a second instance enabled by the first stage's tc.

module tb_updown_counter;

`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, up, load, clr_flag;
  logic [2:0] load_val;
  logic [2:0] state, state_hi;
  logic       tc, wrapped, tc_hi, wrapped_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(3), .MODULUS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .clr_flag (clr_flag),
    .state    (state),
    .tc       (tc),
    .wrapped  (wrapped)
  );

  updown_counter #(.WIDTH(3), .MODULUS(6)) dut_hi (
    .clk      (clk),
    .rst      (rst),
    .en       (tc),
    .up       (up),
    .load     (1'b0),
    .load_val (3'd0),
    .clr_flag (1'b0),
    .state    (state_hi),
    .tc       (tc_hi),
    .wrapped  (wrapped_hi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_dn[4];
    int exp_tc[4];
    int exp_sat[3];
    int lo_e, hi_e;

    if (Sat) begin
      exp_dn  = '{1, 0, 0, 0};
      exp_tc  = '{0, 1, 1, 1};
      exp_sat = '{5, 5, 5};
    end else begin
      exp_dn  = '{1, 0, 5, 4};
      exp_tc  = '{0, 1, 0, 0};
      exp_sat = '{5, 0, 1};
    end

    // Reset held for two edges with load and enable active.
    rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 3'd5; clr_flag = 1'b0;
    step();
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    rst = 1'b1; load_val = 3'd3;
    #2;
    chk("rst_no_async_load", 32'(state), 32'd0);
    load = 1'b0; en = 1'b0;
    step();
    chk("hold_state", 32'(state), 32'd0);
    chk("hold_tc", 32'(tc), 32'd0);

    // Up-count across the wrap.
    en = 1'b1; up = 1'b1;
    #1;
    chk("up_tc0", 32'(tc), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("up_state", 32'(state), 32'(i));
      chk("up_tc", 32'(tc), (i == 5) ? 32'd1 : 32'd0);
      chk("up_wrapped_low", 32'(wrapped), 32'd0);
    end
    step();
    chk("up_wrap_state", 32'(state), Sat ? 32'd5 : 32'd0);
    chk("up_wrap_flag", 32'(wrapped), 32'd1);

    en = 1'b0; clr_flag = 1'b1;
    step();
    chk("clr_flag", 32'(wrapped), 32'd0);
    clr_flag = 1'b0;

    // Down-count from 2 then direction flip.
    load = 1'b1; load_val = 3'd2;
    step();
    chk("load2", 32'(state), 32'd2);
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dn_state", 32'(state), 32'(exp_dn[i]));
      chk("dn_tc", 32'(tc), 32'(exp_tc[i]));
    end
    chk("dn_wrapped", 32'(wrapped), 32'd1);
    up = 1'b1;
    step();
    chk("flip_up", 32'(state), Sat ? 32'd1 : 32'd5);

    en = 1'b0; clr_flag = 1'b1;
    step();
    chk("clr_flag2", 32'(wrapped), 32'd0);
    clr_flag = 1'b0;

    // Load priority and clamping.
    load = 1'b1; load_val = 3'd3;
    step();
    chk("load3", 32'(state), 32'd3);
    load_val = 3'd7; en = 1'b1;
    #1;
    chk("load_tc_masked", 32'(tc), 32'd0);
    step();
    chk("clamp7", 32'(state), 32'd5);
    chk("clamp_wrapped", 32'(wrapped), 32'd0);
    load_val = 3'd2;
    step();
    load_val = 3'd6;
    step();
    chk("clamp6", 32'(state), 32'd5);
    load_val = 3'd4; rst = 1'b0;
    step();
    chk("rst_over_load", 32'(state), 32'd0);
    rst = 1'b1;

    // Set/clear race on the wrapped flag.
    load_val = 3'd5;
    step();
    chk("race_load5", 32'(state), 32'd5);
    load = 1'b0; en = 1'b1; up = 1'b1; clr_flag = 1'b1;
    #1;
    chk("race_tc", 32'(tc), 32'd1);
    step();
    chk("race_state", 32'(state), Sat ? 32'd5 : 32'd0);
    chk("race_set_wins", 32'(wrapped), 32'd1);
    en = 1'b0;
    step();
    chk("race_clear", 32'(wrapped), 32'd0);
    clr_flag = 1'b0;

    // Up from 4 for three cycles: saturates or wraps depending on build.
    load = 1'b1; load_val = 3'd4;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_state", 32'(state), 32'(exp_sat[i]));
    end
    chk("sat_wrapped", 32'(wrapped), 32'd1);

`ifndef UPDOWN_COUNTER_SATURATE_EN
    // Two-stage cascade counts as one modulus-36 counter.
    en = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    chk("casc_rst_lo", 32'(state), 32'd0);
    chk("casc_rst_hi", 32'(state_hi), 32'd0);
    en = 1'b1; up = 1'b1;
    lo_e = 0; hi_e = 0;
    for (int i = 0; i < 36; i++) begin
      step();
      if (lo_e == 5) begin
        lo_e = 0;
        hi_e = (hi_e + 1) % 6;
      end else begin
        lo_e = lo_e + 1;
      end
      chk("casc_lo", 32'(state), 32'(lo_e));
      chk("casc_hi", 32'(state_hi), 32'(hi_e));
    end
    chk("casc_end_lo", 32'(state), 32'd0);
    chk("casc_end_hi", 32'(state_hi), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
